// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM encoding, error read data
// and the width of the region index carved out of the CPU address.
package mmio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESP   = 2'd2
   } mmio_state_e;

   localparam logic [31:0] DEFAULT_RDATA_C = 32'hffff_ffff;

   // Region index occupies addr[31:region_bits].
   function automatic int region_idx_width(input int region_bits);
      return 32 - region_bits;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Wait-state counter: synchronous clear, saturating increment and a
// terminal-count flag raised when the count reaches TIMEOUT-1.
module mmio_timer #(
   parameter int TIMEOUT = 15,
   localparam int W = $clog2(TIMEOUT + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         count <= '0;
      end else if (inc && (count != W'(TIMEOUT))) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/mmio_interconnect.sv
// Registered request/response interconnect from the CPU data port to
// N_SLAVES peripherals, with timeout, unmapped-region error and fault capture.
module mmio_interconnect
   import mmio_pkg::*;
#(
   parameter int          N_SLAVES      = 4,
   parameter int          REGION_BITS   = 10,
   parameter int          TIMEOUT       = 15,
   parameter logic [31:0] DEFAULT_RDATA = DEFAULT_RDATA_C
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3:0]               cpu_writeb,
   input  logic                     cpu_read,
   input  logic [31:0]              cpu_addr,
   input  logic [31:0]              cpu_wdata,
   output logic [31:0]              cpu_rdata,
   output logic                     cpu_ready,
   output logic                     cpu_err,
   output logic [4*N_SLAVES-1:0]    s_writeb,
   output logic [N_SLAVES-1:0]      s_read,
   output logic [REGION_BITS-3:0]   s_addr,
   output logic [31:0]              s_wdata,
   input  logic [32*N_SLAVES-1:0]   s_rdata,
   input  logic [N_SLAVES-1:0]      s_ready,
   output logic [31:0]              fault_addr,
   output logic                     fault_valid,
   output logic [7:0]               fault_count,
   input  logic                     fault_clr,
   output mmio_state_e              fsm_state
);

   localparam int IDX_W = region_idx_width(REGION_BITS);
   localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   mmio_state_e state_q, state_d;
   logic [SEL_W-1:0] sel_q;
   logic             err_q;

   logic             req, is_write, mapped;
   logic [IDX_W-1:0] req_idx;
   logic             sel_ready;
   logic [31:0]      sel_rdata;
   logic             timer_clr, timer_inc, timer_tc;
   logic [TMR_W-1:0] timer_cnt_unused;
   logic             fault_hit, rdata_load;
   logic             addr_lsb_unused;

   assign req      = cpu_read | (|cpu_writeb);
   assign is_write = |cpu_writeb;
   assign req_idx  = cpu_addr[31:REGION_BITS];
   assign mapped   = (req_idx < IDX_W'(N_SLAVES));

   assign sel_ready = s_ready[sel_q];
   assign sel_rdata = s_rdata[32*sel_q +: 32];

   assign addr_lsb_unused = ^cpu_addr[1:0];

   // Valid/ready contract: the CPU asserts a request (cpu_read or any
   // cpu_writeb bit) and holds address, data and enables stable until the
   // single-cycle cpu_ready pulse; slaves see a strobe for as long as the
   // transaction is ACTIVE and complete it by raising their own s_ready.

   // The timer only runs while waiting on a slave; any other state parks it at 0.
   assign timer_clr = (state_q != ST_ACTIVE);

   mmio_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (timer_clr),
      .inc   (timer_inc),
      .count (timer_cnt_unused),
      .tc    (timer_tc)
   );

   always_comb begin
      state_d    = state_q;
      timer_inc  = 1'b0;
      fault_hit  = 1'b0;
      rdata_load = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (mapped) begin
                  state_d = ST_ACTIVE;
               end else begin
                  state_d   = ST_RESP;
                  fault_hit = 1'b1;
               end
            end
         end
         ST_ACTIVE: begin
            if (sel_ready) begin
               state_d    = ST_RESP;
               rdata_load = 1'b1;
            end else if (timer_tc) begin
               state_d   = ST_RESP;
               fault_hit = 1'b1;
            end else begin
               timer_inc = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         err_q       <= 1'b0;
         cpu_rdata   <= '0;
         fault_addr  <= '0;
         fault_valid <= 1'b0;
         fault_count <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && req && mapped) begin
            sel_q <= req_idx[SEL_W-1:0];
         end
         if (fault_hit || rdata_load) begin
            err_q <= fault_hit;
         end
         if (rdata_load) begin
            cpu_rdata <= sel_rdata;
         end else if (fault_hit) begin
            cpu_rdata <= DEFAULT_RDATA;
         end
         // A new fault takes priority over a coincident clear.
         if (fault_hit) begin
            fault_addr  <= cpu_addr;
            fault_valid <= 1'b1;
            if (fault_clr) begin
               fault_count <= 8'd1;
            end else if (fault_count != 8'hff) begin
               fault_count <= fault_count + 8'd1;
            end
         end else if (fault_clr) begin
            fault_valid <= 1'b0;
            fault_count <= '0;
         end
      end
   end

   // Strobes go only to the latched slave and only while ACTIVE; write wins over read.
   always_comb begin
      s_read   = '0;
      s_writeb = '0;
      s_addr   = '0;
      s_wdata  = '0;
      if (state_q == ST_ACTIVE) begin
         s_addr  = cpu_addr[REGION_BITS-1:2];
         s_wdata = cpu_wdata;
         if (is_write) begin
            s_writeb[4*sel_q +: 4] = cpu_writeb;
         end else begin
            s_read[sel_q] = cpu_read;
         end
      end
   end

   assign cpu_ready = (state_q == ST_RESP);
   assign cpu_err   = cpu_ready & err_q;
   assign fsm_state = state_q;

endmodule
